// File: rtl/deser_event_packer.sv
// Frames the aligned nibble stream from the header detector into tagged 16-bit words
// (TBM header/trailer, ROC header, pixel hit halves) behind a small valid/ready output FIFO.
module deser_event_packer #(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        davail,
   input  logic [3:0]  nib,
   input  logic        tbm_hdr,
   input  logic        tbm_trl,
   input  logic        roc_hdr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_data,
   output logic        frame_err,
   output logic        overflow
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FullCnt = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {StIdle, StTbmh, StTbmt, StPix} state_e;

   state_e      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [7:0]  sh_q, sh_d;
   logic [3:0]  roc_cnt_q, roc_cnt_d;

   logic [15:0] mem_q [FIFO_DEPTH];
   logic [15:0] mem_d [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          out_valid_q, out_valid_d;
   logic [15:0]   out_data_q, out_data_d;
   logic          frame_err_q, frame_err_d;
   logic          overflow_q, overflow_d;

   logic        any_mk;
   logic        hdr_acc;
   logic        trunc;
   logic        push;
   logic [15:0] push_word;
   logic        pop, full, wr, drop;

   assign any_mk  = tbm_hdr | tbm_trl | roc_hdr;
   assign hdr_acc = davail & tbm_hdr;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         sh_q      <= '0;
         roc_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sh_q      <= sh_d;
         roc_cnt_q <= roc_cnt_d;
      end
   end

   // Next-state: markers restart a field from any state, ranked hdr > trl > roc
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sh_d      = sh_q;
      roc_cnt_d = roc_cnt_q;
      trunc     = 1'b0;
      if (davail) begin
         if (any_mk) begin
            trunc = (state_q != StIdle) && (cnt_q != 3'd0);
            cnt_d = '0;
            if (tbm_hdr) begin
               state_d   = StTbmh;
               roc_cnt_d = '0;
            end else if (tbm_trl) begin
               state_d = StTbmt;
            end else begin
               state_d = StPix;
               if (roc_cnt_q != 4'hf) roc_cnt_d = roc_cnt_q + 4'd1;
            end
         end else begin
            unique case (state_q)
               StTbmh, StTbmt: begin
                  sh_d = {sh_q[3:0], nib};
                  if (cnt_q == 3'd1) begin
                     state_d = StIdle;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + 3'd1;
                  end
               end
               StPix: begin
                  sh_d  = {sh_q[3:0], nib};
                  cnt_d = (cnt_q == 3'd5) ? 3'd0 : cnt_q + 3'd1;
               end
               default: ;
            endcase
         end
      end
   end

   // Output: word pushed toward the FIFO this cycle
   always_comb begin
      push      = 1'b0;
      push_word = '0;
      if (davail) begin
         if (any_mk) begin
            if (!tbm_hdr && !tbm_trl) begin
               push      = 1'b1;
               push_word = {4'h8, roc_cnt_q, 4'h0, nib};
            end
         end else begin
            unique case (state_q)
               StTbmh, StTbmt: begin
                  if (cnt_q == 3'd1) begin
                     push      = 1'b1;
                     push_word = {(state_q == StTbmh) ? 4'hA : 4'hC, 4'h0, sh_q[3:0], nib};
                  end
               end
               StPix: begin
                  if (cnt_q == 3'd2 || cnt_q == 3'd5) begin
                     push      = 1'b1;
                     push_word = {(cnt_q == 3'd2) ? 4'h4 : 4'h5, sh_q, nib};
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // FIFO; the head is re-registered so every output comes straight from a flop
   always_comb begin
      pop      = out_valid_q & out_ready;
      full     = (count_q == FullCnt);
      wr       = push & (~full | pop);
      drop     = push & full & ~pop;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr) begin
         mem_d[wr_ptr_q] = push_word;
         wr_ptr_d        = wr_ptr_q + AW'(1);
         count_d         = count_d + (AW + 1)'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
         count_d  = count_d - (AW + 1)'(1);
      end
      out_valid_d = (count_d != '0);
      out_data_d  = mem_d[rd_ptr_d];
      // A truncation in the same cycle as the clearing header wins
      frame_err_d = trunc ? 1'b1 : (hdr_acc ? 1'b0 : frame_err_q);
      overflow_d  = hdr_acc ? 1'b0 : (overflow_q | drop);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         frame_err_q <= frame_err_d;
         overflow_q  <= overflow_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign frame_err = frame_err_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_deser_event_packer.sv
// Bench for deser_event_packer: directed scenarios plus random traffic, compared every
// cycle against a field-level reference model with a queue-based FIFO.
module tb_deser_event_packer;

   logic        clk = 1'b0;
   logic        reset;
   logic        davail;
   logic [3:0]  nib;
   logic        tbm_hdr, tbm_trl, roc_hdr;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        frame_err;
   logic        overflow;

   deser_event_packer #(.FIFO_DEPTH(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .davail    (davail),
      .nib       (nib),
      .tbm_hdr   (tbm_hdr),
      .tbm_trl   (tbm_trl),
      .roc_hdr   (roc_hdr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .frame_err (frame_err),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: field kind (0 none, 1 TBM header, 2 TBM trailer, 3 pixel)
   int exp_q[$];
   int nibs[$];
   int mode = 0;
   int roc = 0;
   bit ferr = 1'b0;
   bit ovf = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      nibs.delete();
      mode = 0;
      roc  = 0;
      ferr = 1'b0;
      ovf  = 1'b0;
   endtask

   task automatic model_step(input bit dv, input int n, input bit th, input bit tt,
                             input bit rh, input bit rdy);
      int  word;
      bit  has_push;
      bit  pop;
      bit  trunc;
      has_push = 1'b0;
      word     = 0;
      pop      = rdy && (exp_q.size() > 0);
      if (dv) begin
         if (th || tt || rh) begin
            trunc = (mode != 0) && (nibs.size() != 0);
            nibs.delete();
            if (th) begin
               ferr = trunc;
               ovf  = 1'b0;
               roc  = 0;
               mode = 1;
            end else begin
               if (trunc) ferr = 1'b1;
               if (tt) begin
                  mode = 2;
               end else begin
                  word     = 'h8000 + roc * 256 + n;
                  has_push = 1'b1;
                  if (roc < 15) roc++;
                  mode = 3;
               end
            end
         end else if (mode == 1 || mode == 2) begin
            nibs.push_back(n);
            if (nibs.size() == 2) begin
               word     = ((mode == 1) ? 'hA000 : 'hC000) + nibs[0] * 16 + nibs[1];
               has_push = 1'b1;
               mode     = 0;
               nibs.delete();
            end
         end else if (mode == 3) begin
            nibs.push_back(n);
            if (nibs.size() == 3) begin
               word     = 'h4000 + nibs[0] * 256 + nibs[1] * 16 + nibs[2];
               has_push = 1'b1;
            end else if (nibs.size() == 6) begin
               word     = 'h5000 + nibs[3] * 256 + nibs[4] * 16 + nibs[5];
               has_push = 1'b1;
               nibs.delete();
            end
         end
      end
      if (pop) void'(exp_q.pop_front());
      if (has_push) begin
         if (exp_q.size() >= 4) ovf = 1'b1;
         else exp_q.push_back(word);
      end
   endtask

   task automatic compare_outputs();
      check_eq("out_valid", out_valid, exp_q.size() > 0);
      if (exp_q.size() > 0) check_eq("out_data", out_data, exp_q[0]);
      check_eq("frame_err", frame_err, ferr);
      check_eq("overflow", overflow, ovf);
   endtask

   // One clock: drive at the falling edge, update the model at the rising edge, sample 1 ns later
   task automatic cyc(input bit dv, input int n, input bit th, input bit tt, input bit rh,
                      input bit rdy);
      davail    = dv;
      nib       = 4'(n);
      tbm_hdr   = th;
      tbm_trl   = tt;
      roc_hdr   = rh;
      out_ready = rdy;
      @(posedge clk);
      model_step(dv, n, th, tt, rh, rdy);
      #1;
      compare_outputs();
      @(negedge clk);
   endtask

   task automatic idle(input int k, input bit rdy);
      for (int i = 0; i < k; i++) cyc(1'b0, 0, 1'b0, 1'b0, 1'b0, rdy);
   endtask

   initial begin
      reset     = 1'b0;
      davail    = 1'b0;
      nib       = '0;
      tbm_hdr   = 1'b0;
      tbm_trl   = 1'b0;
      roc_hdr   = 1'b0;
      out_ready = 1'b0;
      #1;
      check_eq("rst_valid", out_valid, 0);
      check_eq("rst_data", out_data, 0);
      check_eq("rst_ferr", frame_err, 0);
      check_eq("rst_ovf", overflow, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      // TBM header with davail every other cycle
      cyc(1, 'h8, 1, 0, 0, 1); idle(1, 1);
      cyc(1, 'h3, 0, 0, 0, 1); idle(1, 1);
      cyc(1, 'hC, 0, 0, 0, 1); idle(2, 1);

      // ROC header and a full pixel, then a second ROC header
      cyc(1, 'h2, 0, 0, 1, 1);
      for (int i = 1; i <= 6; i++) cyc(1, i, 0, 0, 0, 1);
      cyc(1, 'h1, 0, 0, 1, 1);
      idle(3, 1);

      // Truncated pixel followed by a TBM trailer
      cyc(1, 'h8, 1, 0, 0, 1); cyc(1, 'h1, 0, 0, 0, 1); cyc(1, 'h2, 0, 0, 0, 1);
      cyc(1, 'h0, 0, 0, 1, 1);
      for (int i = 0; i < 4; i++) cyc(1, 'h7, 0, 0, 0, 1);
      cyc(1, 'h9, 0, 1, 0, 1); cyc(1, 'h0, 0, 0, 0, 1); cyc(1, 'h5, 0, 0, 0, 1);
      idle(4, 1);

      // Backpressure: five pushes into four slots, drain, then push-with-pop on full
      for (int i = 0; i < 5; i++) cyc(1, i, 0, 0, 1, 0);
      idle(2, 0);
      idle(6, 1);
      for (int i = 0; i < 4; i++) cyc(1, i + 8, 0, 0, 1, 0);
      cyc(1, 'hE, 0, 0, 1, 1);
      idle(6, 1);

      // Priority and gating
      cyc(1, 'h0, 1, 0, 1, 1); cyc(1, 'h1, 0, 0, 0, 1); cyc(1, 'h2, 0, 0, 0, 1);
      cyc(0, 'h5, 1, 1, 1, 1); cyc(0, 'h6, 0, 1, 0, 1);
      cyc(1, 'h7, 0, 1, 1, 1); cyc(1, 'h3, 0, 0, 0, 1); cyc(1, 'h4, 0, 0, 0, 1);
      idle(3, 1);

      // Reset in the middle of a pixel with words queued
      cyc(1, 'h3, 0, 0, 1, 0);
      for (int i = 0; i < 4; i++) cyc(1, i + 1, 0, 0, 0, 0);
      #2;
      reset = 1'b0;
      #1;
      check_eq("midrst_valid", out_valid, 0);
      check_eq("midrst_data", out_data, 0);
      check_eq("midrst_ferr", frame_err, 0);
      check_eq("midrst_ovf", overflow, 0);
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 8; i++) cyc(1, i, 0, 0, 0, 1);
      idle(2, 1);

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         int r;
         bit dv, th, tt, rh, rdy;
         r   = int'($urandom_range(0, 99));
         dv  = ($urandom_range(0, 9) < 7);
         th  = (r < 3) || (r == 50);
         tt  = (r >= 3 && r < 7) || (r == 50) || (r == 51);
         rh  = (r >= 7 && r < 16) || (r == 51);
         rdy = ($urandom_range(0, 9) < ((i / 500) % 2 == 0 ? 6 : 2));
         cyc(dv, int'($urandom_range(0, 15)), th, tt, rh, rdy);
      end
      idle(6, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
